// File: rtl/ps2_kbd_ctrl_if.sv
// Key-event stream from the PS/2 keyboard controller to its consumer.
// The controller drives the head event; the consumer answers with ready.
interface ps2_kbd_ctrl_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_break,
        output ev_ext,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_break,
        input  ev_ext,
        output ev_ready
    );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receive controller.
// Conditions the raw PS/2 lines and frames 11-bit words with parity, stop-bit
// and inter-edge timeout checks. E0/F0 prefixes are folded into single key
// events, which are queued in a small FIFO behind a valid/ready stream.
module ps2_kbd_ctrl #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2_clk_i,
    input  logic                  ps2_data_i,
    ps2_kbd_ctrl_if.master        ev_if,
    output logic                  frame_err_o,
    output logic                  ovf_o,
    input  logic                  clr_ovf_i
);

    localparam int FW = 4;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity holds when the data byte plus parity bit has an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // ---------------------------------------------------------------------
    // Input conditioning
    // ---------------------------------------------------------------------
    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          fclk_q, fclk_d;
    logic          fall_q, fall_d;

    // Two-flop synchronisers; lines reset to the idle-high bus level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    // Filtered clock follows the synchronised clock only after FILTER_LEN equal samples.
    always_comb begin
        flt_cnt_d = flt_cnt_q;
        fclk_d    = fclk_q;
        fall_d    = 1'b0;
        if (clk_sync_q[1] == fclk_q) begin
            flt_cnt_d = 4'd0;
        end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
            fclk_d    = clk_sync_q[1];
            flt_cnt_d = 4'd0;
            fall_d    = fclk_q;
        end else begin
            flt_cnt_d = flt_cnt_q + 4'd1;
        end
    end

    // Filter state registers; the filtered clock starts high like an idle bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flt_cnt_q <= 4'd0;
            fclk_q    <= 1'b1;
            fall_q    <= 1'b0;
        end else begin
            flt_cnt_q <= flt_cnt_d;
            fclk_q    <= fclk_d;
            fall_q    <= fall_d;
        end
    end

    // ---------------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_ok_q, byte_ok_d;
    logic [7:0]    byte_q, byte_d;
    logic          frame_err_q, frame_err_d;
    logic          data_s;

    assign data_s = data_sync_q[1];

    // Frame sequencing, bit capture, parity/stop validation and inter-edge timeout.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        to_cnt_d    = to_cnt_q;
        byte_d      = byte_q;
        byte_ok_d   = 1'b0;
        frame_err_d = 1'b0;
        if (state_q == ST_IDLE) begin
            to_cnt_d = TW'(0);
            if (fall_q && !data_s) begin
                state_d   = ST_DATA;
                bit_cnt_d = 3'd0;
            end else begin
                state_d   = ST_IDLE;
            end
        end else if (fall_q) begin
            to_cnt_d = TW'(0);
            case (state_q)
                ST_DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (data_s && odd_parity_ok(shift_q, par_q)) begin
                        byte_ok_d = 1'b1;
                        byte_d    = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
            frame_err_d = 1'b1;
            to_cnt_d    = TW'(0);
            state_d     = ST_IDLE;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            to_cnt_q    <= TW'(0);
            byte_ok_q   <= 1'b0;
            byte_q      <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            byte_ok_q   <= byte_ok_d;
            byte_q      <= byte_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Prefix decoder
    // ---------------------------------------------------------------------
    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;
    logic       push_s;
    logic [9:0] push_entry_s;

    // Fold E0/F0 prefixes into the next non-prefix byte; any frame error drops them.
    always_comb begin
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        push_s       = 1'b0;
        push_entry_s = {ext_pend_q, brk_pend_q, byte_q};
        if (frame_err_q) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (byte_ok_q) begin
            case (byte_q)
                8'hE0: ext_pend_d = 1'b1;
                8'hF0: brk_pend_d = 1'b1;
                default: begin
                    push_s     = 1'b1;
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                end
            endcase
        end else begin
            ext_pend_d = ext_pend_q;
            brk_pend_d = brk_pend_q;
        end
    end

    // Pending prefix flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
        end else begin
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
        end
    end

    // ---------------------------------------------------------------------
    // Event FIFO
    // ---------------------------------------------------------------------
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          pop_s, full_s, wr_en_s;

    assign pop_s   = (cnt_q != CW'(0)) && ev_if.ev_ready;
    assign full_s  = (cnt_q == CW'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en_s = push_s && (!full_s || pop_s);

    // Pointer/count update and sticky overflow; a fresh overflow beats clr_ovf.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d = (ovf_q && !clr_ovf_i) || (push_s && full_s && !pop_s);
    end

    // FIFO storage and control registers; storage clears so the head reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 10'h000;
            end
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            cnt_q    <= CW'(0);
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= push_entry_s;
            end else begin
                mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ev_if.ev_valid = (cnt_q != CW'(0));
    assign ev_if.ev_ext   = mem_q[rd_ptr_q][9];
    assign ev_if.ev_break = mem_q[rd_ptr_q][8];
    assign ev_if.ev_code  = mem_q[rd_ptr_q][7:0];
    assign frame_err_o    = frame_err_q;
    assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: drives PS/2 frames, predicts key events from the
// protocol rules in a queue-based model, and checks them in a separate monitor.
module tb_ps2_kbd_ctrl;
    localparam int FL   = 4;
    localparam int TO   = 300;
    localparam int FD   = 4;
    localparam int HALF = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic clr_ovf = 1'b0;
    logic frame_err;
    logic ovf;

    ps2_kbd_ctrl_if ev_if();

    ps2_kbd_ctrl #(.FILTER_LEN(FL), .TIMEOUT(TO), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .ev_if      (ev_if.master),
        .frame_err_o(frame_err),
        .ovf_o      (ovf),
        .clr_ovf_i  (clr_ovf)
    );

    int n_checks = 0;
    int n_pass = 0;
    int err_seen = 0;
    int err_exp = 0;
    int valid_cycles = 0;
    int cyc = 0;
    int last_err_cyc = 0;
    int fall_cyc = 0;
    int ready_mode = 0;
    bit force_pop = 1'b0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_e;
    logic m_ext = 1'b0;
    logic m_brk = 1'b0;
    logic ovf_exp = 1'b0;

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Consumer ready driver: 0 = stalled, 1 = always ready, 2 = random.
    initial begin
        ev_if.ev_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (force_pop) ev_if.ev_ready = 1'b1;
            else if (ready_mode == 2) ev_if.ev_ready = 1'($urandom_range(0, 1));
            else ev_if.ev_ready = (ready_mode == 1);
        end
    end

    // Monitor: counts error pulses and compares each accepted event with the model.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (frame_err) begin
                err_seen++;
                last_err_cyc = cyc;
            end
            if (ev_if.ev_valid) valid_cycles++;
            if (ev_if.ev_valid && ev_if.ev_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: got code 0x%0h brk %0b ext %0b, required none",
                             ev_if.ev_code, ev_if.ev_break, ev_if.ev_ext);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event", {22'd0, ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code}, {22'd0, mon_e});
                end
            end
        end
    end

    // Reference model of what one received byte means for the event stream.
    task automatic model_byte(input logic [7:0] b, input bit good, input bit sim_pop);
        if (!good) begin
            err_exp++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() < FD || sim_pop) exp_q.push_back({m_ext, m_brk, b});
            else ovf_exp = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic drive_bit(input logic d, input bit pop_req);
        ps2_data = d;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        fall_cyc = cyc;
        if (pop_req) begin
            repeat (3 + FL) @(posedge clk);
            #1 force_pop = 1'b1;
            @(posedge clk);
            #1 force_pop = 1'b0;
            repeat (HALF - 4 - FL) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit sim_pop);
        logic par;
        par = (~^b) ^ bad_par;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 1'b0);
        drive_bit(par, 1'b0);
        model_byte(b, !(bad_par || bad_stop), sim_pop);
        drive_bit(!bad_stop, sim_pop);
        repeat (HALF) @(posedge clk);
    endtask

    task automatic send_partial(input int n_bits);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < n_bits; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic drain(input string name);
        ready_mode = 1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_valid_low"}, ev_if.ev_valid, 1'b0);
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clk);
        check({name, "_valid"}, ev_if.ev_valid, 1'b0);
        check({name, "_code"}, ev_if.ev_code, 8'h00);
        check({name, "_break"}, ev_if.ev_break, 1'b0);
        check({name, "_ext"}, ev_if.ev_ext, 1'b0);
        check({name, "_frame_err"}, frame_err, 1'b0);
        check({name, "_ovf"}, ovf, 1'b0);
    endtask

    initial begin
        int e0;
        int v0;
        int lat;
        logic [7:0] rb;

        // Power-on reset.
        repeat (3) @(posedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);

        // Make code, consumer always ready: valid for exactly one cycle.
        ready_mode = 1;
        v0 = valid_cycles;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        repeat (30) @(posedge clk);
        check("make_valid_width", valid_cycles - v0, 1);
        check("make_consumed", exp_q.size(), 0);

        // Extended break held until the consumer becomes ready.
        ready_mode = 0;
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("extbrk_valid_held", ev_if.ev_valid, 1'b1);
        check("extbrk_head", {ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code}, {1'b1, 1'b1, 8'h75});
        check("extbrk_model_depth", exp_q.size(), 1);
        drain("extbrk");

        // Bad parity, then bad stop bit.
        e0 = err_seen;
        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        send_frame(8'h44, 1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        check("bad_frames_errs", err_seen - e0, 2);
        check("bad_frames_empty", ev_if.ev_valid, 1'b0);

        // A bad frame cancels a pending break prefix.
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        drain("brk_cancel");

        // Timeout after four data bits.
        e0 = err_seen;
        send_partial(4);
        err_exp++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (TO + 40) @(posedge clk);
        check("timeout_errs", err_seen - e0, 1);
        lat = last_err_cyc - fall_cyc;
        check("timeout_latency_in_window", (lat >= TO && lat <= TO + FL + 8), 1'b1);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        drain("after_timeout");

        // Short low glitch on ps2_clk with data low must not start a frame.
        e0 = err_seen;
        ps2_data = 1'b0;
        @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (10) @(posedge clk);
        ps2_data = 1'b1;
        repeat (TO + 40) @(posedge clk);
        check("glitch_no_err", err_seen - e0, 0);
        send_frame(8'h4D, 1'b0, 1'b0, 1'b0);
        drain("after_glitch");

        // Overflow: FIFO_DEPTH + 1 events with the consumer stalled.
        ready_mode = 0;
        for (int i = 0; i < FD + 1; i++) send_frame(8'h15 + 8'(i), 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("ovf_set", ovf, ovf_exp);
        check("ovf_head", ev_if.ev_code, 8'h15);
        @(posedge clk);
        #1 clr_ovf = 1'b1;
        @(posedge clk);
        #1 clr_ovf = 1'b0;
        ovf_exp = 1'b0;
        @(negedge clk);
        check("ovf_cleared", ovf, 1'b0);
        // Push into the full FIFO in the same cycle as a pop.
        send_frame(8'h1A, 1'b0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("push_pop_full_no_ovf", ovf, ovf_exp);
        check("push_pop_full_valid", ev_if.ev_valid, 1'b1);
        drain("overflow");

        // Reset with a queued event and a partial frame in flight.
        ready_mode = 0;
        send_frame(8'h16, 1'b0, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
        send_partial(5);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        ovf_exp = 1'b0;
        repeat (2) @(posedge clk);
        check_reset_outputs("midframe_reset");
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        ready_mode = 1;
        send_frame(8'h24, 1'b0, 1'b0, 1'b0);
        drain("after_reset");

        // Randomised traffic with a randomly stalling consumer.
        ready_mode = 2;
        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(0, 5))
                0: rb = 8'hE0;
                1: rb = 8'hF0;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) send_frame(rb, 1'b1, 1'b0, 1'b0);
                else send_frame(rb, 1'b0, 1'b1, 1'b0);
            end else begin
                send_frame(rb, 1'b0, 1'b0, 1'b0);
            end
        end
        drain("random");
        check("frame_err_total", err_seen, err_exp);
        check("ovf_final", ovf, ovf_exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
